// File: rtl/sop_lut_checker_pkg.sv
// sop_lut_checker shared types and sizing helpers.
// Imported by the top and the truth-table store.
package sop_lut_checker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SWEEP
    } state_t;

    function automatic int depth_of(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int cnt_w(input int n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/sop_lut_checker_tt_store.sv
// Truth-table storage: one indexed write port and two
// combinational read ports (evaluation and sweep).
module tt_store
    import sop_lut_checker_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic            clk,
    input  logic            we,
    input  logic [N_IN-1:0] waddr,
    input  logic            wdata,
    input  logic [N_IN-1:0] raddr_eval,
    output logic            rdata_eval,
    input  logic [N_IN-1:0] raddr_sweep,
    output logic            rdata_sweep
);

    localparam int DEPTH = depth_of(N_IN);

    logic [DEPTH-1:0] bits;

    // Table bits carry no reset; validity is tracked by the owner.
    always_ff @(posedge clk) begin
        if (we) begin
            bits[waddr] <= wdata;
        end
    end

    assign rdata_eval  = bits[raddr_eval];
    assign rdata_sweep = bits[raddr_sweep];

endmodule

// File: rtl/sop_lut_checker.sv
// Serially loaded N-input truth table with registered evaluation
// and an exhaustive sweep checker against an external function.
module sop_lut_checker
    import sop_lut_checker_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    input  logic                   load_bit,
    output logic                   load_ready,
    input  logic [N_IN-1:0]        in_vec,
    output logic                   f_out,
    output logic                   table_valid,
    output logic [cnt_w(N_IN)-1:0] ones_cnt,
    input  logic                   sweep_start,
    output logic [N_IN-1:0]        sweep_vec,
    input  logic                   dut_f,
    output logic                   busy,
    output logic                   done,
    output logic [cnt_w(N_IN)-1:0] mismatch_cnt,
    output logic                   any_bad,
    output logic [N_IN-1:0]        first_bad
);

    localparam int              CW   = cnt_w(N_IN);
    localparam logic [N_IN-1:0] LAST = '1;
    localparam logic [N_IN-1:0] ONE  = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CONE = {{N_IN{1'b0}}, 1'b1};

    state_t          state;
    state_t          state_nxt;
    logic [N_IN-1:0] idx;
    logic [N_IN-1:0] waddr;
    logic            accept;
    logic            tbl_we;
    logic            sweep_go;
    logic            sweep_end;
    logic            rd_eval;
    logic            rd_sweep;
    logic            miss;
    logic [CW-1:0]   bit_inc;

    assign load_ready = (state != SWEEP);
    assign busy       = (state != IDLE);
    assign accept     = load_valid & load_ready;
    assign miss       = (state == SWEEP) && (dut_f != rd_sweep);
    assign bit_inc    = {{N_IN{1'b0}}, load_bit};

    tt_store #(
        .N_IN(N_IN)
    ) u_tt_store (
        .clk        (clk),
        .we         (tbl_we),
        .waddr      (waddr),
        .wdata      (load_bit),
        .raddr_eval (in_vec),
        .rdata_eval (rd_eval),
        .raddr_sweep(sweep_vec),
        .rdata_sweep(rd_sweep)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and control strobes; a load beat beats a sweep request.
    always_comb begin
        state_nxt = state;
        tbl_we    = 1'b0;
        waddr     = idx;
        sweep_go  = 1'b0;
        sweep_end = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    tbl_we    = 1'b1;
                    waddr     = '0;
                    state_nxt = LOAD;
                end else if (sweep_start && table_valid) begin
                    sweep_go  = 1'b1;
                    state_nxt = SWEEP;
                end
            end
            LOAD: begin
                if (accept) begin
                    tbl_we = 1'b1;
                    if (idx == LAST) begin
                        state_nxt = IDLE;
                    end
                end
            end
            SWEEP: begin
                if (sweep_vec == LAST) begin
                    sweep_end = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Load index, counters, sweep results and the registered evaluation.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= '0;
            table_valid  <= 1'b0;
            ones_cnt     <= '0;
            sweep_vec    <= '0;
            mismatch_cnt <= '0;
            any_bad      <= 1'b0;
            first_bad    <= '0;
            done         <= 1'b0;
            f_out        <= 1'b0;
        end else begin
            done  <= sweep_end;
            f_out <= table_valid & rd_eval;
            if (tbl_we) begin
                if (state == IDLE) begin
                    idx         <= ONE;
                    table_valid <= 1'b0;
                    ones_cnt    <= bit_inc;
                end else begin
                    idx      <= idx + ONE;
                    ones_cnt <= ones_cnt + bit_inc;
                    if (idx == LAST) begin
                        table_valid <= 1'b1;
                    end
                end
            end
            if (sweep_go) begin
                sweep_vec    <= '0;
                mismatch_cnt <= '0;
                any_bad      <= 1'b0;
                first_bad    <= '0;
            end
            if (state == SWEEP) begin
                sweep_vec <= sweep_vec + ONE;
                if (miss) begin
                    mismatch_cnt <= mismatch_cnt + CONE;
                    if (!any_bad) begin
                        any_bad   <= 1'b1;
                        first_bad <= sweep_vec;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sop_lut_checker.sv
// Randomised self-checking bench for sop_lut_checker
// (N_IN=4 main instance, N_IN=3 secondary instance).
module tb_sop_lut_checker;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        load_valid, load_bit, load_ready, f_out, table_valid;
    logic        sweep_start, dut_f, busy, done, any_bad;
    logic [3:0]  in_vec, sweep_vec, first_bad;
    logic [4:0]  ones_cnt, mismatch_cnt;
    logic [15:0] ext_tt;

    logic        load_valid_n3, load_bit_n3, load_ready_n3, f_out_n3;
    logic        table_valid_n3, sweep_start_n3, dut_f_n3, busy_n3;
    logic        done_n3, any_bad_n3;
    logic [2:0]  in_vec_n3, sweep_vec_n3, first_bad_n3;
    logic [3:0]  ones_cnt_n3, mismatch_cnt_n3;
    logic [7:0]  ext_tt_n3;

    assign dut_f    = ext_tt[sweep_vec];
    assign dut_f_n3 = ext_tt_n3[sweep_vec_n3];

    sop_lut_checker #(.N_IN(4)) u_dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_bit(load_bit),
        .load_ready(load_ready), .in_vec(in_vec), .f_out(f_out),
        .table_valid(table_valid), .ones_cnt(ones_cnt),
        .sweep_start(sweep_start), .sweep_vec(sweep_vec),
        .dut_f(dut_f), .busy(busy), .done(done),
        .mismatch_cnt(mismatch_cnt), .any_bad(any_bad),
        .first_bad(first_bad)
    );

    sop_lut_checker #(.N_IN(3)) u_dut_n3 (
        .clk(clk), .rst(rst),
        .load_valid(load_valid_n3), .load_bit(load_bit_n3),
        .load_ready(load_ready_n3), .in_vec(in_vec_n3),
        .f_out(f_out_n3), .table_valid(table_valid_n3),
        .ones_cnt(ones_cnt_n3), .sweep_start(sweep_start_n3),
        .sweep_vec(sweep_vec_n3), .dut_f(dut_f_n3),
        .busy(busy_n3), .done(done_n3),
        .mismatch_cnt(mismatch_cnt_n3), .any_bad(any_bad_n3),
        .first_bad(first_bad_n3)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] model_tt;
    bit          model_valid;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Simplified SOP of 0xE8F9: A'B + CD + ABD + ABC + A'B'C'D'.
    function automatic bit simp_f(input logic [3:0] v);
        bit a, b, c, d;
        {a, b, c, d} = v;
        return (!a && b) || (c && d) || (a && b && d) || (a && b && c)
            || (!a && !b && !c && !d);
    endfunction

    task automatic load4(input logic [15:0] tt, input bit gaps,
                         input bit with_start);
        int ones = 0;
        for (int i = 0; i < 16; i++) begin
            load_valid  = 1'b1;
            load_bit    = tt[i];
            sweep_start = with_start;
            step();
            ones += int'(tt[i]);
            check("load_busy_tv", {busy, table_valid},
                  {i != 15, i == 15});
            check("load_ones_run", ones_cnt, ones);
            load_valid  = 1'b0;
            sweep_start = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) step();
        end
        model_tt    = tt;
        model_valid = 1'b1;
        check("ones_cnt", ones_cnt, $countones(tt));
    endtask

    task automatic eval4(input int n);
        logic [3:0] v;
        for (int i = 0; i < n; i++) begin
            v      = 4'($urandom);
            in_vec = v;
            step();
            check("f_out", f_out, model_valid ? model_tt[v] : 1'b0);
        end
    endtask

    // Ends in the done cycle so a caller can start back-to-back.
    task automatic sweep4(input logic [15:0] ext);
        int         exp_cnt   = 0;
        int         exp_first = 0;
        bit         seen      = 0;
        logic [3:0] v;
        for (int i = 0; i < 16; i++) begin
            if (ext[i] != model_tt[i]) begin
                exp_cnt++;
                if (!seen) begin
                    seen      = 1;
                    exp_first = i;
                end
            end
        end
        ext_tt      = ext;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        check("sweep_clr", {any_bad, mismatch_cnt}, 0);
        for (int k = 0; k < 16; k++) begin
            check("sweep_vec", sweep_vec, k);
            check("sweep_busy_done", {busy, done, load_ready}, 3'b100);
            v      = 4'($urandom);
            in_vec = v;
            step();
            check("sweep_f_out", f_out, model_tt[v]);
        end
        check("done_pulse", {done, busy, load_ready}, 3'b101);
        check("mismatch_cnt", mismatch_cnt, exp_cnt);
        check("any_bad", any_bad, seen);
        check("first_bad", first_bad, exp_first);
        check("sweep_vec_wrap", sweep_vec, 0);
    endtask

    initial begin
        logic [15:0] t, m, simp_tt;
        logic [7:0]  xor3;
        logic [2:0]  iv;
        int          n;

        rst            = 1'b1;
        load_valid     = 1'b0;
        load_bit       = 1'b0;
        sweep_start    = 1'b0;
        in_vec         = '0;
        ext_tt         = '0;
        load_valid_n3  = 1'b0;
        load_bit_n3    = 1'b0;
        sweep_start_n3 = 1'b0;
        in_vec_n3      = '0;
        ext_tt_n3      = '0;
        model_tt       = '0;
        model_valid    = 1'b0;
        repeat (2) step();
        rst = 1'b0;

        check("rst_ready_busy_done", {load_ready, busy, done}, 3'b100);
        check("rst_tv_f", {table_valid, f_out}, 0);
        check("rst_counts", {ones_cnt, mismatch_cnt}, 0);
        check("rst_bad", {any_bad, first_bad, sweep_vec}, 0);
        eval4(2);

        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        check("start_no_table", busy, 0);
        step();
        check("start_no_table_done", done, 0);

        load4(16'hE8F9, 1'b0, 1'b1);
        check("tp_ones", ones_cnt, 10);
        in_vec = 4'b0011;
        step();
        check("tp_f_0011", f_out, 1);
        in_vec = 4'b1000;
        step();
        check("tp_f_1000", f_out, 0);
        eval4(6);

        for (int i = 0; i < 16; i++) simp_tt[i] = simp_f(4'(i));
        sweep4(simp_tt);
        check("tp_simp", {any_bad, mismatch_cnt, first_bad}, 0);
        step();
        check("done_once", done, 0);
        check("hold_res", {any_bad, mismatch_cnt}, 0);

        sweep4(16'hE8F9 ^ 16'h0840);
        check("tp_flip_cnt", mismatch_cnt, 2);
        check("tp_flip_first", {any_bad, first_bad}, {1'b1, 4'd6});
        sweep4(16'hE8F9);
        step();

        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        repeat (7) step();
        check("rst_at7_vec", sweep_vec, 7);
        rst = 1'b1;
        step();
        rst         = 1'b0;
        model_valid = 1'b0;
        check("mid_rst_state", {busy, load_ready, table_valid}, 3'b010);
        check("mid_rst_counts", {ones_cnt, mismatch_cnt}, 0);
        check("mid_rst_bad", {any_bad, first_bad, sweep_vec, done}, 0);
        step();
        check("mid_rst_no_done", done, 0);
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        check("post_rst_ignore", busy, 0);
        eval4(2);

        for (int r = 0; r < 6; r++) begin
            t = 16'($urandom);
            load4(t, 1'b1, r[0]);
            eval4(4);
            m = (r == 2) ? 16'h0 : 16'($urandom & $urandom & $urandom);
            sweep4(t ^ m);
            if (r[1]) step();
        end

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) step();
            load_valid_n3 = 1'b1;
            load_bit_n3   = 8'h96 >> i;
            step();
            load_valid_n3 = 1'b0;
        end
        check("n3_tv", table_valid_n3, 1);
        check("n3_ones", ones_cnt_n3, 4);
        in_vec_n3 = 3'd7;
        step();
        check("n3_f_7", f_out_n3, 1);

        for (int i = 0; i < 8; i++) begin
            iv      = 3'(i);
            xor3[i] = ^iv;
        end
        ext_tt_n3      = xor3;
        sweep_start_n3 = 1'b1;
        step();
        sweep_start_n3 = 1'b0;
        n = 0;
        while (busy_n3 && n < 20) begin
            step();
            n++;
        end
        check("n3_cycles", n, 8);
        check("n3_done", done_n3, 1);
        check("n3_xor", {any_bad_n3, mismatch_cnt_n3, first_bad_n3}, 0);

        ext_tt_n3      = xor3 ^ 8'h81;
        sweep_start_n3 = 1'b1;
        step();
        sweep_start_n3 = 1'b0;
        n = 0;
        while (busy_n3 && n < 20) begin
            step();
            n++;
        end
        check("n3_bad_cycles", n, 8);
        check("n3_bad_cnt", mismatch_cnt_n3, 2);
        check("n3_bad_first", {any_bad_n3, first_bad_n3}, {1'b1, 3'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
